// File: rtl/product_accumulator.sv
// product_accumulator
// Sums N_TERMS unsigned 8-bit products from a 4x4 array multiplier into an
// ACC_W-bit result. Results are presented with a valid/ready handshake.
// A sticky overflow flag is reported alongside each result.
// Optional build macro: PRODUCT_ACC_SAT_EN.
//   Defined:   an overflowing add clamps the sum at 2^ACC_W-1.
//   Undefined: an overflowing add wraps modulo 2^ACC_W.

module product_accumulator #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       prod_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clr,
  output logic [ACC_W-1:0] res_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    HOLD
  } state_t;

  // Counter value held while the final term is being accepted in ACC.
  localparam logic [7:0] LAST_CNT = 8'(N_TERMS - 1);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [7:0]       cnt;
  logic             ovf_q;
  logic             res_valid_q;

  logic             accept;
  logic [ACC_W:0]   sum_wide;
  logic             carry;
  logic [ACC_W-1:0] next_acc;

  // Handshake decode: readiness follows state only, and is gated off by reset and clr.
  always_comb begin
    in_ready = 1'b0;
    if (!rst && !clr && (state != HOLD)) begin
      in_ready = 1'b1;
    end
    accept = in_valid & in_ready;
  end

  // Running-sum adder with one extra bit to expose the overflow carry.
  always_comb begin
    sum_wide = {1'b0, acc} + (ACC_W + 1)'(prod_in);
    carry    = sum_wide[ACC_W];
`ifdef PRODUCT_ACC_SAT_EN
    next_acc = carry ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
    next_acc = sum_wide[ACC_W-1:0];
`endif
  end

  // Control FSM and datapath registers. clr outranks every handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      ovf_q       <= 1'b0;
      res_valid_q <= 1'b0;
    end else if (clr) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      ovf_q       <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc   <= ACC_W'(prod_in);
            cnt   <= 8'd1;
            ovf_q <= 1'b0;
            if (N_TERMS == 1) begin
              state       <= HOLD;
              res_valid_q <= 1'b1;
            end else begin
              state <= ACC;
            end
          end
        end
        ACC: begin
          if (accept) begin
            acc <= next_acc;
            cnt <= cnt + 8'd1;
            if (carry) begin
              ovf_q <= 1'b1;
            end
            if (cnt == LAST_CNT) begin
              state       <= HOLD;
              res_valid_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (res_ready) begin
            state       <= IDLE;
            cnt         <= '0;
            res_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // The result bus always mirrors the accumulator; consumers qualify it with res_valid.
  always_comb begin
    res_data  = acc;
    res_valid = res_valid_q;
    ovf       = ovf_q;
  end

endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator
// Directed bench for product_accumulator. Three instances share one set of
// inputs: the default configuration, an 8-bit/2-term build for overflow,
// and a single-term build. Expected values are hand-computed constants.

module tb_product_accumulator;

  logic       clk;
  logic       rst;
  logic [7:0] prod_in;
  logic       in_valid;
  logic       clr;
  logic       res_ready;

  logic        a_in_ready, a_res_valid, a_ovf;
  logic [11:0] a_res_data;
  logic        b_in_ready, b_res_valid, b_ovf;
  logic [7:0]  b_res_data;
  logic        c_in_ready, c_res_valid, c_ovf;
  logic [11:0] c_res_data;

  int total;
  int bad;

`ifdef PRODUCT_ACC_SAT_EN
  localparam logic [15:0] OVF_RESULT = 16'h00FF;
`else
  localparam logic [15:0] OVF_RESULT = 16'h0001;
`endif

  product_accumulator #(.N_TERMS(4), .ACC_W(12)) dut_a (
    .clk(clk), .rst(rst), .prod_in(prod_in), .in_valid(in_valid),
    .in_ready(a_in_ready), .clr(clr), .res_data(a_res_data),
    .res_valid(a_res_valid), .res_ready(res_ready), .ovf(a_ovf)
  );

  product_accumulator #(.N_TERMS(2), .ACC_W(8)) dut_b (
    .clk(clk), .rst(rst), .prod_in(prod_in), .in_valid(in_valid),
    .in_ready(b_in_ready), .clr(clr), .res_data(b_res_data),
    .res_valid(b_res_valid), .res_ready(res_ready), .ovf(b_ovf)
  );

  product_accumulator #(.N_TERMS(1), .ACC_W(12)) dut_c (
    .clk(clk), .rst(rst), .prod_in(prod_in), .in_valid(in_valid),
    .in_ready(c_in_ready), .clr(clr), .res_data(c_res_data),
    .res_valid(c_res_valid), .res_ready(res_ready), .ovf(c_ovf)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends even if a step stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle of inputs, then land 1 unit after the rising edge.
  task automatic applyStimulus(input logic v, input logic [7:0] p,
                               input logic c, input logic r);
    in_valid  = v;
    prod_in   = p;
    clr       = c;
    res_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs,
                             input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Synchronous-looking reset pulse aligned to falling edges.
  task automatic doReset();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b0;
    prod_in   = 8'h00;
    clr       = 1'b0;
    res_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    prod_in   = 8'h00;
    clr       = 1'b0;
    res_ready = 1'b0;

    // Reset state, observed without any clock edge.
    #1 rst = 1'b1;
    #1;
    $display("[TB] reset state");
    checkOutput("rst_in_ready",  16'(a_in_ready),  16'h0);
    checkOutput("rst_res_valid", 16'(a_res_valid), 16'h0);
    checkOutput("rst_res_data",  16'(a_res_data),  16'h0);
    checkOutput("rst_ovf",       16'(a_ovf),       16'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", 16'(a_in_ready), 16'h1);

    // Four back-to-back 0xE1 terms.
    $display("[TB] basic run");
    applyStimulus(1'b1, 8'hE1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hE1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hE1, 1'b0, 1'b0);
    checkOutput("basic_valid_early", 16'(a_res_valid), 16'h0);
    applyStimulus(1'b1, 8'hE1, 1'b0, 1'b0);
    checkOutput("basic_valid",    16'(a_res_valid), 16'h1);
    checkOutput("basic_data",     16'(a_res_data),  16'h0384);
    checkOutput("basic_ovf",      16'(a_ovf),       16'h0);
    checkOutput("basic_in_ready", 16'(a_in_ready),  16'h0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("basic_drain_valid", 16'(a_res_valid), 16'h0);
    checkOutput("basic_drain_ready", 16'(a_in_ready),  16'h1);

    // Terms with bubbles, then held under backpressure.
    $display("[TB] bubbles and backpressure");
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h77, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h02, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h77, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h03, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h77, 1'b0, 1'b0);
    checkOutput("bubble_not_done", 16'(a_res_valid), 16'h0);
    applyStimulus(1'b1, 8'h04, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
      checkOutput("bp_valid", 16'(a_res_valid), 16'h1);
      checkOutput("bp_data",  16'(a_res_data),  16'h000A);
      checkOutput("bp_ready", 16'(a_in_ready),  16'h0);
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("bp_drain_valid", 16'(a_res_valid), 16'h0);
    checkOutput("bp_drain_ready", 16'(a_in_ready),  16'h1);

    // clr after two terms aborts the run; a fresh run follows.
    $display("[TB] clear mid-run");
    applyStimulus(1'b1, 8'h10, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h10, 1'b0, 1'b0);
    in_valid = 1'b1;
    prod_in  = 8'h20;
    clr      = 1'b1;
    #1;
    checkOutput("clr_in_ready", 16'(a_in_ready), 16'h0);
    @(posedge clk);
    #1;
    checkOutput("clr_data", 16'(a_res_data), 16'h0);
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h02, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h03, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h04, 1'b0, 1'b0);
    checkOutput("clr_run_valid", 16'(a_res_valid), 16'h1);
    checkOutput("clr_run_data",  16'(a_res_data),  16'h000A);
    checkOutput("clr_run_ovf",   16'(a_ovf),       16'h0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    // Asynchronous reset while a result is pending.
    $display("[TB] async reset in HOLD");
    applyStimulus(1'b1, 8'h40, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h40, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h40, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h40, 1'b0, 1'b0);
    checkOutput("hold_valid", 16'(a_res_valid), 16'h1);
    checkOutput("hold_data",  16'(a_res_data),  16'h0100);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    checkOutput("arst_valid",    16'(a_res_valid), 16'h0);
    checkOutput("arst_data",     16'(a_res_data),  16'h0);
    checkOutput("arst_in_ready", 16'(a_in_ready),  16'h0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
    checkOutput("arst_run_valid", 16'(a_res_valid), 16'h1);
    checkOutput("arst_run_data",  16'(a_res_data),  16'h0004);

    // Overflow on the 8-bit, 2-term instance.
    $display("[TB] overflow");
    doReset();
    applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
    checkOutput("ovf_first_ovf", 16'(b_ovf), 16'h0);
    applyStimulus(1'b1, 8'h02, 1'b0, 1'b0);
    checkOutput("ovf_valid", 16'(b_res_valid), 16'h1);
    checkOutput("ovf_data",  16'(b_res_data),  OVF_RESULT);
    checkOutput("ovf_flag",  16'(b_ovf),       16'h1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("ovf_sticky_idle", 16'(b_ovf), 16'h1);
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
    checkOutput("ovf_cleared", 16'(b_ovf), 16'h0);

    // Single-term instance.
    $display("[TB] single term");
    doReset();
    applyStimulus(1'b1, 8'h37, 1'b0, 1'b0);
    checkOutput("one_valid",    16'(c_res_valid), 16'h1);
    checkOutput("one_data",     16'(c_res_data),  16'h0037);
    checkOutput("one_in_ready", 16'(c_in_ready),  16'h0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("one_drain", 16'(c_res_valid), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL provide parameter N_TERMS, default 4, meaning number of products summed per result (legal 1..255).
REQ-002 SHALL provide parameter ACC_W, default 12, meaning accumulator and result width in bits (legal 8..16).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port prod_in  input  8  unsigned product from the 4x4 array multiplier.
REQ-006 SHALL have port in_valid  input  1  prod_in holds a valid product.
REQ-007 SHALL have port in_ready  output  1  block accepts prod_in this cycle.
REQ-008 SHALL have port clr  input  1  synchronous abort of the current accumulation.
REQ-009 SHALL have port res_data  output  ACC_W  accumulated sum.
REQ-010 SHALL have port res_valid  output  1  res_data holds a completed result.
REQ-011 SHALL have port res_ready  input  1  consumer takes the result this cycle.
REQ-012 SHALL have port ovf  output  1  sticky overflow flag for the current result.

Function
REQ-013 SHALL implement states IDLE, ACC and HOLD, with an 8-bit term counter cnt.
REQ-014 SHALL drive in_ready=1 in IDLE and ACC and in_ready=0 in HOLD; in_ready SHALL depend only on state, rst and clr, never on in_valid.
REQ-015 Accept SHALL mean in_valid & in_ready & ~clr at a rising edge; cycles with in_valid=0 SHALL NOT count as terms.
REQ-016 Accept in IDLE: acc<=zero-extended prod_in, cnt<=1, ovf<=0; next state HOLD if N_TERMS==1, else ACC.
REQ-017 Accept in ACC: acc<=acc+prod_in, cnt<=cnt+1; next state HOLD when the accepted term is term N_TERMS, else ACC.
REQ-018 res_valid SHALL be 1 exactly in HOLD and SHALL assert the cycle after the last term is accepted (latency 1).
REQ-019 In HOLD, res_data and ovf SHALL remain stable until res_valid & res_ready; that edge returns to IDLE, and no input is accepted in that cycle.
REQ-020 res_data SHALL always equal acc; consumers treat it as meaningful only while res_valid=1.
REQ-021 Overflow: if acc+prod_in exceeds 2^ACC_W-1, ovf SHALL set and remain set until the next IDLE accept, clr or rst.
REQ-022 clr=1 SHALL take priority over every handshake in every state: next state IDLE, acc<=0, cnt<=0, ovf<=0, in_ready=0 in that cycle, and any pending result discarded.

Reset
REQ-023 While rst=1, without waiting for a clock edge: state=IDLE, acc=0, cnt=0, ovf=0, res_valid=0, res_data=0, in_ready=0.
REQ-024 The first rising edge after rst deasserts SHALL see in_ready=1 (IDLE).
REQ-025 rst asserted during ACC or HOLD SHALL discard the partial sum or pending result with no output pulse.

Configuration
REQ-026 When macro PRODUCT_ACC_SAT_EN is defined, an overflowing add SHALL clamp acc to 2^ACC_W-1, and later terms SHALL keep it clamped.
REQ-027 When PRODUCT_ACC_SAT_EN is not defined, an overflowing add SHALL wrap modulo 2^ACC_W; ovf behaviour is identical in both builds.

Verification
REQ-028 Basic: defaults; accept 0xE1 four times back-to-back -> res_valid=1 one cycle after 4th accept, res_data=0x384, ovf=0.
REQ-029 Bubbles/backpressure: terms 1,2,3,4 with idle cycles between them; res_ready=0 for 5 cycles -> res_data=0x00A held, res_valid=1, in_ready=0, extra in_valid ignored; res_ready=1 -> IDLE next cycle.
REQ-030 Overflow: ACC_W=8, N_TERMS=2, terms 0xFF then 0x02 -> with PRODUCT_ACC_SAT_EN res_data=0xFF, else 0x01; ovf=1 in both builds.
REQ-031 clr mid-run: clr after 2 accepted terms (0x10,0x10), then terms 1,2,3,4 -> res_data=0x00A, ovf=0; in_valid during the clr cycle is not accepted.
REQ-032 Async reset: assert rst between clock edges while in HOLD -> res_valid, res_data and in_ready go to 0 immediately; after release a fresh 4-term run (0x01 each) gives 0x004.
REQ-033 N_TERMS=1: one accept of 0x37 -> res_valid next cycle with res_data=0x037.
